// File: rtl/conv1d_pkg.sv
// Shared types and helpers for the 1-D convolution MAC sequencer.
package conv1d_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_F  = 3'd1,
    ST_LOAD_X  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_OUT     = 3'd5
  } conv1d_state_e;

  localparam int WIDTH_DEF   = 14;
  localparam int MAC_LAT_DEF = 2;

  // Accumulator width: one full product plus headroom for summing m of them.
  function automatic int acc_w(input int width, input int m);
    return 2 * width + $clog2(m);
  endfunction

  function automatic logic signed [63:0] sat_2w(input logic signed [63:0] v, input int w2);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w2 - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w2 - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/conv1d_sample_buf.sv
// Small register file: one synchronous write port, one combinational read port.
module conv1d_sample_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 14,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv1d_mac_seq.sv
// Sequencer for one valid-mode 1-D convolution: loads taps and samples, drives
// the external pipelined MAC, accumulates products and streams saturated results.
module conv1d_mac_seq
  import conv1d_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int M       = 3,
  parameter int N       = 8,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [2*WIDTH-1:0] m_data,
  output logic                      done,
  output logic [WIDTH-1:0]          mac_a,
  output logic [WIDTH-1:0]          mac_b,
  output logic                      mac_enable_mult,
  output logic                      mac_en_pipeline_reg,
  output logic                      mac_clear_pipeline_mult,
  output logic                      mac_clear_reg,
  input  logic signed [2*WIDTH-1:0] mac_product,
  output conv1d_state_e             dbg_state
);

  localparam int ACC_W = acc_w(WIDTH, M);
  localparam int IW    = $clog2(N + 1);
  localparam int FAW   = (M > 1) ? $clog2(M) : 1;
  localparam int XAW   = (N > 1) ? $clog2(N) : 1;
  localparam int DW    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  conv1d_state_e            state_q, state_d;
  logic [IW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            j_q, j_d;
  logic [IW-1:0]            k_q, k_d;
  logic [DW-1:0]            dcnt_q, dcnt_d;
  logic [MAC_LAT-1:0]       iv_q, iv_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     done_q, done_d;

  logic                     f_we, x_we, issue, acc_clr, mac_en;
  logic [WIDTH-1:0]         f_rdata, x_rdata;

  conv1d_sample_buf #(.DEPTH(M), .WIDTH(WIDTH), .AW(FAW)) u_fbuf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (f_we),
    .waddr_i (FAW'(cnt_q)),
    .wdata_i (s_data),
    .raddr_i (FAW'(k_q)),
    .rdata_o (f_rdata)
  );

  conv1d_sample_buf #(.DEPTH(N), .WIDTH(WIDTH), .AW(XAW)) u_xbuf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (x_we),
    .waddr_i (XAW'(cnt_q)),
    .wdata_i (s_data),
    .raddr_i (XAW'(j_q + k_q)),
    .rdata_o (x_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
      iv_q    <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      iv_q    <= iv_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  // Both streams use plain valid/ready: a beat transfers on a cycle where
  // valid && ready; a raised m_valid keeps m_data stable until accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    f_we    = 1'b0;
    x_we    = 1'b0;
    issue   = 1'b0;
    acc_clr = 1'b0;
    s_ready = 1'b0;
    m_valid = 1'b0;
    mac_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_F;
          cnt_d   = '0;
        end
      end
      ST_LOAD_F: begin
        s_ready = 1'b1;
        if (s_valid) begin
          f_we = 1'b1;
          if (cnt_q == IW'(M - 1)) begin
            state_d = ST_LOAD_X;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD_X: begin
        s_ready = 1'b1;
        if (s_valid) begin
          x_we = 1'b1;
          if (cnt_q == IW'(N - 1)) begin
            state_d = ST_COMPUTE;
            cnt_d   = '0;
            j_d     = '0;
            k_d     = '0;
            acc_clr = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        mac_en = 1'b1;
        issue  = 1'b1;
        if (k_q == IW'(M - 1)) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        mac_en = 1'b1;
        if (dcnt_q == DW'(MAC_LAT - 1)) state_d = ST_OUT;
        else dcnt_d = dcnt_q + 1'b1;
      end
      ST_OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (j_q == IW'(N - M)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_COMPUTE;
            j_d     = j_q + 1'b1;
            k_d     = '0;
            acc_clr = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The delayed issue flag lines up with the MAC's product for that issue.
    iv_d = MAC_LAT'({iv_q, issue});
    if (acc_clr) acc_d = '0;
    else if (iv_q[MAC_LAT-1]) acc_d = acc_q + ACC_W'(mac_product);
    else acc_d = acc_q;
  end

  assign mac_a                   = (state_q == ST_COMPUTE) ? x_rdata : '0;
  assign mac_b                   = (state_q == ST_COMPUTE) ? f_rdata : '0;
  assign mac_enable_mult         = mac_en;
  assign mac_en_pipeline_reg     = mac_en;
  assign mac_clear_pipeline_mult = reset || (state_q == ST_IDLE);
  assign mac_clear_reg           = reset || (state_q == ST_IDLE);
  assign m_data = (state_q == ST_OUT) ? (2*WIDTH)'(sat_2w(64'(acc_q), 2 * WIDTH)) : '0;
  assign done                    = done_q;
  assign dbg_state               = state_q;

endmodule

// File: tb/tb_conv1d_mac_seq.sv
// Bench for conv1d_mac_seq paired with a two-stage MAC pipeline model.
module tb_conv1d_mac_seq;
  import conv1d_pkg::*;

  localparam int W   = 14;
  localparam int M   = 3;
  localparam int N   = 8;
  localparam int LAT = 2;
  localparam int NY  = N - M + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [W-1:0] s_data = '0;
  logic m_valid;
  logic m_ready = 1'b1;
  logic [2*W-1:0] m_data;
  logic done;
  logic signed [W-1:0] mac_a, mac_b;
  logic mac_enable_mult, mac_en_pipeline_reg, mac_clear_pipeline_mult, mac_clear_reg;
  logic signed [2*W-1:0] mult_q, prod_q;
  conv1d_state_e dbg_state;

  conv1d_mac_seq #(.WIDTH(W), .M(M), .N(N), .MAC_LAT(LAT)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .s_valid                 (s_valid),
    .s_ready                 (s_ready),
    .s_data                  (s_data),
    .m_valid                 (m_valid),
    .m_ready                 (m_ready),
    .m_data                  (m_data),
    .done                    (done),
    .mac_a                   (mac_a),
    .mac_b                   (mac_b),
    .mac_enable_mult         (mac_enable_mult),
    .mac_en_pipeline_reg     (mac_en_pipeline_reg),
    .mac_clear_pipeline_mult (mac_clear_pipeline_mult),
    .mac_clear_reg           (mac_clear_reg),
    .mac_product             (prod_q),
    .dbg_state               (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC pipeline: multiply stage then product register
  always_ff @(posedge clk) begin
    if (mac_clear_pipeline_mult) mult_q <= '0;
    else if (mac_enable_mult) mult_q <= mac_a * mac_b;
    if (mac_clear_reg) prod_q <= '0;
    else if (mac_en_pipeline_reg) prod_q <= mult_q;
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic signed [W-1:0] f_v[M];
  logic signed [W-1:0] x_v[N];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] ref_y(input int j);
    longint s;
    longint hi;
    longint lo;
    s  = 0;
    hi = (longint'(1) <<< (2*W - 1)) - 1;
    lo = -hi - 1;
    for (int k = 0; k < M; k++) s += longint'(f_v[k]) * longint'(x_v[j + k]);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return (2*W)'(s);
  endfunction

  // monitor
  int n_res = 0;
  int done_cnt = 0;
  int last_hs_cyc = 0;
  int comp_start = 0;
  bit first_pending = 0;
  bit stall_seen = 0;
  bit prev_stall = 0;
  logic [2*W-1:0] prev_data;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid) check("mac_en_in_out", {mac_enable_mult, mac_en_pipeline_reg}, 0);
      if (dbg_state == ST_COMPUTE) check("s_ready_compute", s_ready, 0);
      if (m_valid && first_pending) begin
        check("first_latency", cyc - comp_start, M + LAT);
        first_pending = 0;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_result", 1, 0);
        else check("y", m_data, exp_q.pop_front());
        if (n_res > 0 && !stall_seen) check("spacing", cyc - last_hs_cyc, M + LAT + 1);
        last_hs_cyc = cyc;
        n_res++;
        stall_seen = 0;
      end
      if (m_valid && !m_ready) stall_seen = 1;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) begin
        done_cnt++;
        check("done_timing", cyc, last_hs_cyc + 1);
        check("done_idle", dbg_state, ST_IDLE);
      end
    end
  end

  // random backpressure
  bit rand_ready = 0;
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // driver tasks
  task automatic load_frame(input int bubble_pct, input bit start_mid);
    int t;
    n_res = 0;
    stall_seen = 0;
    for (int j = 0; j < NY; j++) exp_q.push_back(ref_y(j));
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < M + N; i++) begin
      while ($urandom_range(0, 99) < bubble_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = (i < M) ? f_v[i] : x_v[i - M];
      start   = start_mid && (i == M + 2);
      t = 0;
      while (!s_ready && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      if (!s_ready) check("s_ready_timeout", s_ready, 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    s_valid = 1'b0;
    comp_start = cyc;
    first_pending = 1;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int t;
    d0 = done_cnt;
    t = 0;
    while (done_cnt == d0 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("frame_done", done_cnt != d0, 1);
    check("result_count", n_res, NY);
    check("queue_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    exp_q.delete();
  endtask

  task automatic set_basic();
    f_v = '{14'sd1, 14'sd2, 14'sd3};
    for (int i = 0; i < N; i++) x_v[i] = W'(i + 1);
  endtask

  task automatic wait_until_res(input int nres, input bit want_compute);
    int t;
    t = 0;
    while (!(n_res == nres && (want_compute ? (dbg_state == ST_COMPUTE) : m_valid)) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_point", t < 200, 1);
  endtask

  initial begin
    // reset values
    @(negedge clk);
    check("clear_in_reset", {mac_clear_pipeline_mult, mac_clear_reg}, 2'b11);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_done", done, 0);
    check("rst_mac_ab", {mac_a, mac_b}, 0);
    check("rst_enables", {mac_enable_mult, mac_en_pipeline_reg}, 0);
    check("rst_clears", {mac_clear_pipeline_mult, mac_clear_reg}, 2'b11);

    // basic convolution
    set_basic();
    load_frame(0, 0);
    wait_done(500);

    // positive saturation
    for (int k = 0; k < M; k++) f_v[k] = 14'sd8191;
    for (int i = 0; i < N; i++) x_v[i] = 14'sd8191;
    load_frame(0, 0);
    wait_done(500);

    // negative saturation
    for (int k = 0; k < M; k++) f_v[k] = 14'h2000;
    load_frame(0, 0);
    wait_done(500);

    // mixed signs, no false saturation
    f_v = '{14'sd1, -14'sd1, 14'sd0};
    for (int i = 0; i < N; i++) x_v[i] = 14'sd5;
    load_frame(0, 0);
    wait_done(500);

    // backpressure on second result
    set_basic();
    load_frame(0, 0);
    wait_until_res(1, 0);
    m_ready = 1'b0;
    check("bp_data", m_data, 28'd20);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", m_valid, 1);
    end
    m_ready = 1'b1;
    wait_done(500);

    // reset during compute of third result, then full reload
    load_frame(0, 0);
    wait_until_res(2, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_clears", {mac_clear_pipeline_mult, mac_clear_reg}, 2'b11);
    check("mid_rst_s_ready", s_ready, 0);
    exp_q.delete();
    first_pending = 0;
    load_frame(0, 0);
    wait_done(500);

    // start while busy, load bubbles, stray s_valid while computing
    load_frame(40, 1);
    s_valid = 1'b1;
    s_data  = W'($urandom_range(0, 16383));
    wait_until_res(0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(500);
    s_valid = 1'b0;
    check("idle_after_busy_start", dbg_state, ST_IDLE);
    check("s_ready_idle", s_ready, 0);

    // randomized frames with random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < M; k++) f_v[k] = W'($urandom_range(0, 16383));
      for (int i = 0; i < N; i++) x_v[i] = W'($urandom_range(0, 16383));
      rand_ready = 1;
      load_frame(25, 0);
      wait_done(1000);
      rand_ready = 0;
      @(posedge clk); #2;
      m_ready = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv1d_mac_seq.md
# conv1d_mac_seq

Sequencer that drives the pipelined 14×14 MAC datapath for one 1-D valid-mode convolution. It accepts M filter taps and then N input samples over a valid/ready stream, and stores them in local register files. It then issues tap pairs to the MAC, accumulates the returned products, and emits the N−M+1 saturated results on a valid/ready output stream. It is the initiator that owns every MAC control strobe; the MAC instance sits beside it at the conv-layer level.

## Interface
Parameters:
- WIDTH, 14, operand width for samples and taps (signed)
- M, 3, filter taps; 1 ≤ M ≤ N
- N, 8, input samples per frame
- MAC_LAT, 2, cycles from a/b presented to mac_product valid with enables high

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins frame load; honoured only in IDLE
- s_valid  in  1  input beat valid
- s_ready  out  1  high in LOAD_F / LOAD_X
- s_data  in  WIDTH  first M beats = f[0..M−1], next N beats = x[0..N−1]
- m_valid  out  1  result valid
- m_ready  in  1  downstream accept
- m_data  out  2*WIDTH  result y[j], signed, saturated
- done  out  1  one-cycle pulse after last result accepted
- mac_a, mac_b  out  WIDTH  MAC operands
- mac_enable_mult, mac_en_pipeline_reg  out  1  MAC pipeline advance
- mac_clear_pipeline_mult, mac_clear_reg  out  1  MAC pipeline clear
- mac_product  in  2*WIDTH  MAC pipeline register output

## Operation
- States: IDLE, LOAD_F, LOAD_X, COMPUTE, DRAIN, OUT.
- IDLE → LOAD_F on start. LOAD_F stores f[k] on each s_valid&&s_ready beat and moves to LOAD_X after the M-th beat. LOAD_X stores x[i] and moves to COMPUTE after the N-th beat, with j=0.
- COMPUTE: for k=0..M−1 on consecutive cycles, mac_a=x[j+k], mac_b=f[k]. A MAC_LAT-deep issue-valid shift register marks returning products. After k=M−1 the FSM moves to DRAIN.
- DRAIN: runs MAC_LAT cycles, then moves to OUT.
- Accumulator: signed, ACC_W = 2*WIDTH + clog2(M) bits. It is cleared on entry to COMPUTE. It adds sign-extended mac_product when the delayed issue-valid is high.
- OUT: m_valid=1, and m_data is the accumulator saturated to [−2^(2W−1), 2^(2W−1)−1].
  - On m_ready: if j==N−M, go to IDLE and pulse done; otherwise increment j and go to COMPUTE.
- MAC strobes:
  - mac_enable_mult = mac_en_pipeline_reg = 1 in COMPUTE and DRAIN, 0 otherwise, so the MAC is frozen.
  - mac_clear_pipeline_mult = mac_clear_reg = 1 in IDLE and during reset.
- start outside IDLE is ignored. s_valid outside the load states is ignored (s_ready=0).

## Timing
- Reset values:
  - state=IDLE, j=k=0, accumulator=0, issue-valid=0.
  - s_ready=0, m_valid=0, m_data=0, done=0.
  - mac_a=mac_b=0, enables=0, clears=1.
- Reset mid-operation: the next cycle is IDLE with the values above. The partial frame is discarded, and a new start reloads both f and x.
- Load: one beat per cycle at full rate; stalls follow s_valid.
- Per result: M COMPUTE + MAC_LAT DRAIN + ≥1 OUT cycles. With m_ready held high, results are spaced exactly M+MAC_LAT+1 cycles apart.
- First m_valid rises M+MAC_LAT cycles after the COMPUTE entry.
- m_data and m_valid hold stable while m_valid && !m_ready.
- done is asserted in the cycle after the final handshake, coincident with IDLE.
- M=1: COMPUTE lasts one cycle; otherwise the flow is unchanged.

## Structure
- Package conv1d_pkg holds:
  - state enum typedef
  - WIDTH and MAC_LAT defaults
  - ACC_W function
  - saturate-to-2W function
- Sub-module conv1d_sample_buf: parameterised register file (depth, WIDTH) with write port (we, waddr, wdata) and combinational read. It is instantiated twice, for f (depth M) and x (depth N).
- The FSM, counters, issue-valid shift register and accumulator live in conv1d_mac_seq.
- The bench pairs the block with the MAC pipeline so that mac_product latency is MAC_LAT=2.

## Test plan
- Basic convolution: M=3, N=8, f={1,2,3}, x={1..8}, m_ready=1.
  - y = 14, 20, 26, 32, 38, 44.
  - Exactly 6 results, each 6 cycles apart.
  - done pulses once.
- Positive saturation: f={8191,8191,8191}, x all 8191.
  - Raw sum 201,277,443; every y = 134,217,727.
- Negative saturation: f all −8192, x all 8191.
  - Every y = −134,217,728.
  - Mixed case f={1,−1,0}, x={5,5,…} gives y=0, with no false saturation.
- Backpressure: m_ready low for 5 cycles during the 2nd result.
  - m_data holds 20 and m_valid stays high.
  - mac enables stay 0 during the stall.
  - The next result is 26.
- Reset in COMPUTE of the 3rd result.
  - Next cycle: IDLE, m_valid=0, clears=1.
  - A new start plus reload of the basic vectors reproduces 14…44.
- Start while busy: start pulsed in LOAD_X and in OUT has no effect.
  - s_valid bubbles during load give correct results, and s_ready is 0 in COMPUTE.
